osd_flip_scheduler: RTL and testbench

Sequences one OSD reprocessing pass around the flipping component. On start it latches the most-reliable-information (MRI) vector, launches the flipping component and waits for its completion. It then snapshots the candidate list and streams the order-0 candidate (MRI itself) followed by every generated candidate, one per beat, over a valid/ready interface to the re-encoding/metric stage. A watchdog and an abort path bound each pass.

---
 rtl/osd_flip_scheduler.sv | 173 +++++++++++++++++
 tb/tb_osd_flip_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_flip_scheduler.sv
// Runs one OSD reprocessing pass: launch the flipping component, snapshot its list, stream MRI + candidates.
// Latency: flip_start 1 cycle after start; first beat 1 cycle after flip_done; done 1 cycle after last beat.
// Backpressure: beats hold registered and stable while cand_valid=1 and cand_ready=0; abort drops the pass.
module osd_flip_scheduler #(
  parameter int K       = 8,
  parameter int TOTAL   = K + K*(K-1)/2,
  parameter int TIMEOUT = 1024,
  parameter int IW      = $clog2(TOTAL+2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [K-1:0]       a1k_flat,
  output logic               flip_start,
  input  logic               flip_done,
  input  logic [TOTAL*K-1:0] candidates,
  input  logic [31:0]        candidate_count,
  output logic               cand_valid,
  input  logic               cand_ready,
  output logic [K-1:0]       cand_data,
  output logic [IW-1:0]      cand_idx,
  output logic               cand_last,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
);

  localparam int WW = $clog2(TIMEOUT+1);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_GEN, S_STREAM, S_FINISH} state_t;

  state_t             state_q, state_d;
  logic [K-1:0]       mri_q, mri_d;
  logic [TOTAL*K-1:0] list_q, list_d;
  logic [IW-1:0]      num_q, num_d;
  logic [WW-1:0]      wd_q, wd_d;
  logic               flip_start_q, flip_start_d;
  logic               cand_valid_q, cand_valid_d;
  logic [K-1:0]       cand_data_q, cand_data_d;
  logic [IW-1:0]      cand_idx_q, cand_idx_d;
  logic               cand_last_q, cand_last_d;
  logic               done_q, done_d;
  logic               timeout_err_q, timeout_err_d;

  logic [IW-1:0]      num_sat;
  logic [IW-1:0]      idx_nxt;
  logic [K-1:0]       nxt_slice;

  // Saturated list length and the slice that follows the beat currently presented
  always_comb begin
    num_sat   = (candidate_count > 32'(TOTAL)) ? IW'(TOTAL) : candidate_count[IW-1:0];
    idx_nxt   = cand_idx_q + IW'(1);
    nxt_slice = '0;
    // Beat idx+1 carries list slice idx; guard the final index, which has no slice
    if (int'(cand_idx_q) < TOTAL) nxt_slice = list_q[int'(cand_idx_q)*K +: K];
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    mri_d         = mri_q;
    list_d        = list_q;
    num_d         = num_q;
    wd_d          = wd_q;
    flip_start_d  = 1'b0;
    cand_valid_d  = cand_valid_q;
    cand_data_d   = cand_data_q;
    cand_idx_d    = cand_idx_q;
    cand_last_d   = cand_last_q;
    done_d        = 1'b0;
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mri_d         = a1k_flat;
          timeout_err_d = 1'b0;
          flip_start_d  = 1'b1;
          state_d       = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_WAIT_GEN;
      end
      S_WAIT_GEN: begin
        wd_d = wd_q + WW'(1);
        // flip_done is checked first so it wins over a same-cycle watchdog expiry
        if (flip_done) begin
          list_d       = candidates;
          num_d        = num_sat;
          cand_valid_d = 1'b1;
          cand_idx_d   = '0;
          cand_data_d  = mri_q;
          cand_last_d  = (num_sat == '0);
          state_d      = S_STREAM;
        end else if (wd_q == WW'(TIMEOUT-1)) begin
          timeout_err_d = 1'b1;
          state_d       = S_FINISH;
        end
      end
      S_STREAM: begin
        if (cand_ready) begin
          if (cand_last_q) begin
            cand_valid_d = 1'b0;
            cand_last_d  = 1'b0;
            done_d       = 1'b1;
            state_d      = S_FINISH;
          end else begin
            cand_idx_d  = idx_nxt;
            cand_data_d = nxt_slice;
            cand_last_d = (idx_nxt == num_q);
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything outside IDLE, including a last transfer; timeout_err is kept
    if (abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      cand_valid_d = 1'b0;
      cand_last_d  = 1'b0;
      flip_start_d = 1'b0;
      done_d       = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mri_q         <= '0;
      list_q        <= '0;
      num_q         <= '0;
      wd_q          <= '0;
      flip_start_q  <= 1'b0;
      cand_valid_q  <= 1'b0;
      cand_data_q   <= '0;
      cand_idx_q    <= '0;
      cand_last_q   <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mri_q         <= mri_d;
      list_q        <= list_d;
      num_q         <= num_d;
      wd_q          <= wd_d;
      flip_start_q  <= flip_start_d;
      cand_valid_q  <= cand_valid_d;
      cand_data_q   <= cand_data_d;
      cand_idx_q    <= cand_idx_d;
      cand_last_q   <= cand_last_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign flip_start  = flip_start_q;
  assign cand_valid  = cand_valid_q;
  assign cand_data   = cand_data_q;
  assign cand_idx    = cand_idx_q;
  assign cand_last   = cand_last_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_osd_flip_scheduler.sv
// Directed bench for osd_flip_scheduler: nominal, backpressure, saturation, zero, timeout, abort, reset.
module tb_osd_flip_scheduler;

  localparam int K       = 8;
  localparam int TOTAL   = K + K*(K-1)/2;
  localparam int TIMEOUT = 64;
  localparam int IW      = $clog2(TOTAL+2);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [K-1:0]       a1k_flat = '0;
  logic               flip_start;
  logic               flip_done = 1'b0;
  logic [TOTAL*K-1:0] candidates = '0;
  logic [31:0]        candidate_count = '0;
  logic               cand_valid;
  logic               cand_ready = 1'b0;
  logic [K-1:0]       cand_data;
  logic [IW-1:0]      cand_idx;
  logic               cand_last;
  logic               busy;
  logic               done;
  logic               timeout_err;

  int checks = 0;
  int errors = 0;
  logic [K-1:0] mri = 8'hA5;

  osd_flip_scheduler #(.K(K), .TOTAL(TOTAL), .TIMEOUT(TIMEOUT), .IW(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .a1k_flat(a1k_flat),
    .flip_start(flip_start), .flip_done(flip_done), .candidates(candidates),
    .candidate_count(candidate_count), .cand_valid(cand_valid), .cand_ready(cand_ready),
    .cand_data(cand_data), .cand_idx(cand_idx), .cand_last(cand_last),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [K-1:0] exp_beat(input int i);
    logic [K-1:0] v;
    v = (i == 0) ? mri : (8'hA5 ^ 8'(i));
    return v;
  endfunction

  task automatic load_list();
    for (int j = 0; j < TOTAL; j++) candidates[j*K +: K] = 8'hA5 ^ 8'(j+1);
  endtask

  // Accept start; returns at the negedge of the LAUNCH cycle
  task automatic do_start(input logic [K-1:0] v);
    mri = v;
    start = 1'b1;
    a1k_flat = v;
    @(negedge clk);
    start = 1'b0;
    chk("launch_flip_start", 32'(flip_start), 32'd1);
    chk("launch_busy", 32'(busy), 32'd1);
    chk("launch_timeout_err", 32'(timeout_err), 32'd0);
  endtask

  // Flipping-component model: flip_done 20 cycles after flip_start
  task automatic gen(input int count);
    @(negedge clk);
    chk("flip_start_pulse", 32'(flip_start), 32'd0);
    repeat (10) @(negedge clk);
    chk("wait_no_valid", 32'(cand_valid), 32'd0);
    repeat (9) @(negedge clk);
    flip_done = 1'b1;
    candidate_count = 32'(count);
    @(negedge clk);
    flip_done = 1'b0;
    chk("first_valid", 32'(cand_valid), 32'd1);
    chk("first_idx", 32'(cand_idx), 32'd0);
  endtask

  // Drain the stream; rmode 0 = always ready, 1 = ready pattern 1,0,0,1; abort_at>=0 aborts at that beat
  task automatic stream(input int num, input int rmode, input int abort_at);
    int beat = 0;
    int cyc = 0;
    bit fin = 0;
    bit stalled = 0;
    logic [K-1:0] pd = '0;
    logic [IW-1:0] pi = '0;
    while (!fin && cyc < 400) begin
      if (stalled) begin
        chk("stall_data", 32'(cand_data), 32'(pd));
        chk("stall_idx", 32'(cand_idx), 32'(pi));
      end
      cand_ready = (rmode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (abort_at >= 0 && beat == abort_at) begin
        abort = 1'b1;
        fin = 1;
      end
      if (cand_valid && cand_ready) begin
        chk("beat_idx", 32'(cand_idx), 32'(beat));
        chk("beat_data", 32'(cand_data), 32'(exp_beat(beat)));
        chk("beat_last", 32'(cand_last), 32'(beat == num));
        if (cand_last) fin = 1;
        beat++;
      end
      stalled = cand_valid && !cand_ready;
      pd = cand_data;
      pi = cand_idx;
      cyc++;
      @(negedge clk);
    end
    abort = 1'b0;
    cand_ready = 1'b0;
    if (!fin) chk("stream_bound_expired", 32'd0, 32'd1);
    if (abort_at < 0) chk("beat_count", 32'(beat), 32'(num + 1));
  endtask

  task automatic finish_checks();
    chk("fin_done", 32'(done), 32'd1);
    chk("fin_valid", 32'(cand_valid), 32'd0);
    chk("fin_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_flip_start"}, 32'(flip_start), 32'd0);
    chk({tag, "_valid"}, 32'(cand_valid), 32'd0);
    chk({tag, "_data"}, 32'(cand_data), 32'd0);
    chk({tag, "_idx"}, 32'(cand_idx), 32'd0);
    chk({tag, "_last"}, 32'(cand_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    load_list();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    reset_checks("rst");

    // Nominal pass, count=36, always ready
    do_start(8'hA5);
    gen(36);
    stream(36, 0, -1);
    finish_checks();

    // Backpressure with a different MRI; candidates corrupted after the snapshot
    do_start(8'h3C);
    gen(36);
    candidates = '0;
    stream(36, 1, -1);
    finish_checks();
    load_list();

    // Saturated count
    do_start(8'hA5);
    gen(100);
    stream(36, 0, -1);
    finish_checks();

    // Zero count: single MRI beat with cand_last
    do_start(8'hA5);
    gen(0);
    chk("zero_last", 32'(cand_last), 32'd1);
    stream(0, 0, -1);
    finish_checks();

    // Watchdog expiry
    do_start(8'h5A);
    repeat (64) @(negedge clk);
    chk("to_not_yet", 32'(timeout_err), 32'd0);
    chk("to_no_valid", 32'(cand_valid), 32'd0);
    @(negedge clk);
    chk("to_set", 32'(timeout_err), 32'd1);
    chk("to_no_done", 32'(done), 32'd0);
    chk("to_finish_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("to_idle_busy", 32'(busy), 32'd0);
    chk("to_idle_done", 32'(done), 32'd0);
    chk("to_sticky", 32'(timeout_err), 32'd1);
    do_start(8'hA5);
    gen(36);
    stream(36, 0, -1);
    finish_checks();

    // Abort mid-stream at beat 10
    do_start(8'hA5);
    gen(36);
    stream(36, 0, 10);
    chk("abort_valid", 32'(cand_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("abort_no_done", 32'(done), 32'd0);

    // Abort coinciding with the last (only) transfer
    do_start(8'hA5);
    gen(0);
    stream(0, 0, 0);
    chk("abort_last_done", 32'(done), 32'd0);
    chk("abort_last_busy", 32'(busy), 32'd0);

    // Full pass after abort
    do_start(8'hA5);
    gen(36);
    stream(36, 0, -1);
    finish_checks();

    // start during STREAM is ignored
    do_start(8'hA5);
    gen(36);
    cand_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_flip", 32'(flip_start), 32'd0);
    chk("busy_start_valid", 32'(cand_valid), 32'd1);
    chk("busy_start_idx", 32'(cand_idx), 32'd0);
    stream(36, 0, -1);
    finish_checks();

    // Reset during WAIT_GEN, then a normal pass
    do_start(8'hA5);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_checks("midrst");
    do_start(8'hA5);
    gen(36);
    stream(36, 0, -1);
    finish_checks();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
